cfg_bitstream_loader: RTL and testbench
=======================================

// Module: cfg_bitstream_loader
// PURPOSE
//  Serial configuration loader feeding the 3x3 fabric top's parallel 116-bit config bus.
//  Receives a framed serial stream: sync word, CFG_WIDTH config bits, CRC-8.
//  Writes the config word to the fabric only after the CRC passes, so the fabric never
//  sees a partial or corrupt config.
//  Sits between the off-chip config pins and the fabric's bitstream input.
// PARAMETERS
//  CFG_WIDTH   116     config bits per frame; output bus width
//  SYNC_WIDTH  8       sync word length in bits
//  SYNC_WORD   8'hA5   frame-start pattern, received MSB first
//  CRC_POLY    8'h07   CRC-8 polynomial (x^8+x^2+x+1), init 8'h00, no reflect, no final xor
// PORTS
//  clk        in   1          single clock; all logic on rising edge
//  reset      in   1          asynchronous, active-low reset
//  cfg_valid  in   1          cfg_bit is valid this cycle
//  cfg_bit    in   1          serial config data
//  cfg_ready  out  1          loader accepts a bit; bit transfers when cfg_valid && cfg_ready
//  bitstream  out  CFG_WIDTH  committed config word to the fabric
//  cfg_done   out  1          last frame committed with good CRC
//  cfg_error  out  1          last frame failed CRC; bitstream left unchanged
// BEHAVIOUR
//  Reset (reset==0, async): state=HUNT; bitstream=0; cfg_done=0; cfg_error=0;
//   shadow, CRC, sync and bit counter cleared. cfg_ready=1 (state-decoded, HUNT).
//  Transfer: one bit per cycle when cfg_valid && cfg_ready. Idle cycles (valid=0) freeze
//   all state, counters and the CRC.
//  cfg_ready = (state != COMMIT).
//  States:
//   HUNT: shift accepted bits into an SYNC_WIDTH-bit sliding window (new bit at LSB).
//    On a match including the bit just accepted: clear cnt and CRC, clear cfg_done and
//    cfg_error, go to LOAD. Overlapping patterns must be detected; no window reset on mismatch.
//   LOAD: shift each bit into shadow[CFG_WIDTH-1:0] (first bit lands at shadow[CFG_WIDTH-1],
//    i.e. MSB first). Update CRC per bit: fb=crc[7]^bit; crc={crc[6:0],1'b0}^(fb?CRC_POLY:0).
//    cnt counts 0..CFG_WIDTH-1. Go to CHECK on the CFG_WIDTH-th accepted bit.
//   CHECK: shift 8 received CRC bits (MSB first) into rx_crc; the CRC is frozen.
//    On the 8th bit, compare {rx_crc[6:0],bit} with crc:
//     equal  -> COMMIT
//     differ -> cfg_error=1, go to HUNT
//   COMMIT (exactly 1 cycle, cfg_ready=0): bitstream<=shadow; cfg_done=1; go to HUNT.
//  Latency: bitstream and cfg_done update on the clock edge after the cycle in which
//   the last CRC bit is accepted (one edge for COMMIT entry, one for the update).
//  cfg_done and cfg_error are levels, mutually exclusive. They hold until the next sync
//   match, or until reset.
//  bitstream changes only in COMMIT or on reset. Partial frames, CRC failures and
//   re-hunting never disturb it.
//  Sync patterns appearing inside LOAD or CHECK data are treated as data, not re-sync.
//  Reset mid-frame: immediate return to reset values. The previously committed bitstream
//   is lost (cleared to 0).
//  Sync window persists across frames. After COMMIT or error, hunting resumes with the
//   window as it stands.
//  Counter width = $clog2(CFG_WIDTH). No wrap beyond CFG_WIDTH-1.
// STRUCTURE
//  Shared package cfg_pkg:
//   CFG_WIDTH, SYNC_WORD, SYNC_WIDTH, CRC_POLY constants
//   state encoding localparams HUNT=2'd0, LOAD=2'd1, CHECK=2'd2, COMMIT=2'd3
//  Sub-module crc8_serial (clk, reset, clr, en, bit_in, crc[7:0]) holds the per-bit CRC
//   update. Used by the bench golden model too.
//  The remainder is one FSM plus shift registers in this module.
// TESTING
//  1 Sync A5, 116 zeros, CRC 00, valid held 1 -> cfg_done=1, bitstream=0, cfg_error=0;
//    cfg_ready low for exactly 1 cycle.
//  2 Sync A5, 116 zeros, CRC 01 -> cfg_error=1, cfg_done=0; bitstream keeps its prior
//    committed value (load pattern X first, then this frame; X is retained).
//  3 Sync A5, random 116-bit X, CRC from crc8_serial model, cfg_valid random 50% duty
//    -> bitstream==X, cfg_done=1; result identical to the gap-free run.
//  4 Preamble bits 0x52 then A5 (overlap case), then a valid frame -> frame found,
//    correct commit. A frame whose data contains A5 -> no false re-sync.
//  5 Reset asserted at LOAD bit 60 after a good commit -> all outputs 0 immediately;
//    after reset release, a full good frame commits correctly.
//  6 Two back-to-back good frames X then Y -> bitstream==X, then ==Y;
//    cfg_done drops at Y's sync match and rises at Y's commit.

Source files
------------

// File: rtl/cfg_pkg.sv
// Shared constants, state encoding and the per-bit CRC-8 step for the serial config loader.
package cfg_pkg;

    localparam int CFG_WIDTH  = 116;
    localparam int SYNC_WIDTH = 8;
    localparam int CRC_WIDTH  = 8;
    localparam int CNT_WIDTH  = $clog2(CFG_WIDTH);

    localparam logic [SYNC_WIDTH-1:0] SYNC_WORD = 8'hA5;
    localparam logic [CRC_WIDTH-1:0]  CRC_POLY  = 8'h07;

    localparam logic [CNT_WIDTH-1:0] CNT_LOAD_LAST = CNT_WIDTH'(CFG_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_CRC_LAST  = CNT_WIDTH'(CRC_WIDTH - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // MSB-first CRC-8, init 0, no reflection, no final xor.
    function automatic logic [CRC_WIDTH-1:0] crc8_step(input logic [CRC_WIDTH-1:0] crc,
                                                       input logic                 b);
        logic fb;
        fb = crc[CRC_WIDTH-1] ^ b;
        return {crc[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Serial CRC-8 accumulator: one bit per enabled cycle, synchronous clear wins over enable.
module crc8_serial
    import cfg_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clr,
    input  logic                 en,
    input  logic                 bit_in,
    output logic [CRC_WIDTH-1:0] crc
);

    logic [CRC_WIDTH-1:0] crc_q;
    logic [CRC_WIDTH-1:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clr) begin
            crc_d = '0;
        end else if (en) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/cfg_bitstream_loader.sv
// Framed serial config loader: hunts for the sync word, shadows the config bits and
// commits them to the fabric bus only when the trailing CRC-8 matches.
//
// state  | meaning
// HUNT   | sliding-window search for the sync word
// LOAD   | shifting CFG_WIDTH config bits into the shadow, CRC running
// CHECK  | collecting the 8 received CRC bits, CRC frozen
// COMMIT | single cycle: shadow -> bitstream, input stalled
module cfg_bitstream_loader
    import cfg_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_valid,
    input  logic                 cfg_bit,
    output logic                 cfg_ready,
    output logic [CFG_WIDTH-1:0] bitstream,
    output logic                 cfg_done,
    output logic                 cfg_error
);

    state_t                  state_q,     state_d;
    logic [SYNC_WIDTH-1:0]   sync_q,      sync_d;
    logic [CFG_WIDTH-1:0]    shadow_q,    shadow_d;
    logic [CRC_WIDTH-1:0]    rx_crc_q,    rx_crc_d;
    logic [CNT_WIDTH-1:0]    cnt_q,       cnt_d;
    logic [CFG_WIDTH-1:0]    bitstream_q, bitstream_d;
    logic                    done_q,      done_d;
    logic                    error_q,     error_d;

    logic                    accept;
    logic [SYNC_WIDTH-1:0]   sync_next;
    logic [CRC_WIDTH-1:0]    rx_crc_next;
    logic [CRC_WIDTH-1:0]    crc_calc;
    logic                    crc_clr;
    logic                    crc_en;

    assign cfg_ready   = (state_q != COMMIT);
    assign accept      = cfg_valid && cfg_ready;
    assign sync_next   = {sync_q[SYNC_WIDTH-2:0], cfg_bit};
    assign rx_crc_next = {rx_crc_q[CRC_WIDTH-2:0], cfg_bit};

    crc8_serial u_crc (
        .clk    (clk),
        .reset  (reset),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (cfg_bit),
        .crc    (crc_calc)
    );

    always_comb begin
        state_d     = state_q;
        sync_d      = sync_q;
        shadow_d    = shadow_q;
        rx_crc_d    = rx_crc_q;
        cnt_d       = cnt_q;
        bitstream_d = bitstream_q;
        done_d      = done_q;
        error_d     = error_q;
        crc_clr     = 1'b0;
        crc_en      = 1'b0;

        unique case (state_q)
            HUNT: begin
                // The window only moves while hunting, so it carries over between frames.
                if (accept) begin
                    sync_d = sync_next;
                    if (sync_next == SYNC_WORD) begin
                        cnt_d   = '0;
                        crc_clr = 1'b1;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    shadow_d = {shadow_q[CFG_WIDTH-2:0], cfg_bit};
                    crc_en   = 1'b1;
                    if (cnt_q == CNT_LOAD_LAST) begin
                        cnt_d   = '0;
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    rx_crc_d = rx_crc_next;
                    if (cnt_q == CNT_CRC_LAST) begin
                        cnt_d = '0;
                        if (rx_crc_next == crc_calc) begin
                            state_d = COMMIT;
                        end else begin
                            error_d = 1'b1;
                            state_d = HUNT;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                bitstream_d = shadow_q;
                done_d      = 1'b1;
                state_d     = HUNT;
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= HUNT;
            sync_q      <= '0;
            shadow_q    <= '0;
            rx_crc_q    <= '0;
            cnt_q       <= '0;
            bitstream_q <= '0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            shadow_q    <= shadow_d;
            rx_crc_q    <= rx_crc_d;
            cnt_q       <= cnt_d;
            bitstream_q <= bitstream_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign bitstream = bitstream_q;
    assign cfg_done  = done_q;
    assign cfg_error = error_q;

endmodule

// File: tb/tb_cfg_bitstream_loader.sv
// Directed bench for the serial config loader; expected words and CRCs are built locally.
module tb_cfg_bitstream_loader;

    localparam int W = 116;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         cfg_valid = 1'b0;
    logic         cfg_bit = 1'b0;
    logic         cfg_ready;
    logic [W-1:0] bitstream;
    logic         cfg_done;
    logic         cfg_error;

    int total = 0;
    int bad   = 0;

    cfg_bitstream_loader dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_valid (cfg_valid),
        .cfg_bit   (cfg_bit),
        .cfg_ready (cfg_ready),
        .bitstream (bitstream),
        .cfg_done  (cfg_done),
        .cfg_error (cfg_error)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_crc(input logic [W-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = W - 1; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the transfer edge.
    task automatic send_bit(input logic b, input bit gaps);
        int guard;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                cfg_valid = 1'b0;
                cfg_bit   = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        guard = 0;
        while (!cfg_ready && guard < 4) begin
            cfg_valid = 1'b0;
            @(negedge clk);
            guard++;
        end
        if (!cfg_ready) begin
            total++;
            bad++;
            $error("FAIL ready_timeout observed=%0b expected=1", cfg_ready);
        end
        cfg_valid = 1'b1;
        cfg_bit   = b;
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v, input bit gaps);
        for (int i = 7; i >= 0; i--) send_bit(v[i], gaps);
    endtask

    task automatic send_data(input logic [W-1:0] d, input bit gaps);
        for (int i = W - 1; i >= 0; i--) send_bit(d[i], gaps);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic [7:0] c, input bit gaps);
        send_byte(8'hA5, gaps);
        send_data(d, gaps);
        send_byte(c, gaps);
    endtask

    // Entered right after the last CRC bit: COMMIT cycle with valid held high, then result.
    task automatic check_commit(input string tag, input logic [W-1:0] exp);
        chk({tag, "_ready_low"}, cfg_ready, 1'b0);
        chk({tag, "_done_pre"}, cfg_done, 1'b0);
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        cfg_bit   = 1'b0;
        chk({tag, "_ready_back"}, cfg_ready, 1'b1);
        chk({tag, "_done"}, cfg_done, 1'b1);
        chk({tag, "_error"}, cfg_error, 1'b0);
        chk({tag, "_bitstream"}, bitstream, exp);
    endtask

    initial begin
        logic [W-1:0] x, y;

        #1;
        chk("rst_bitstream", bitstream, '0);
        chk("rst_done", cfg_done, 1'b0);
        chk("rst_error", cfg_error, 1'b0);
        chk("rst_ready", cfg_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // 1: all-zero frame, CRC of zeros is zero
        send_frame('0, 8'h00, 1'b0);
        check_commit("t1", '0);

        // 2: good X, then a zero frame with a wrong CRC must not disturb X
        x = rand_word();
        send_frame(x, ref_crc(x), 1'b0);
        check_commit("t2_x", x);
        send_frame('0, 8'h01, 1'b0);
        chk("t2_error", cfg_error, 1'b1);
        chk("t2_done", cfg_done, 1'b0);
        chk("t2_ready", cfg_ready, 1'b1);
        chk("t2_keep", bitstream, x);
        repeat (3) @(negedge clk);
        chk("t2_error_hold", cfg_error, 1'b1);

        // 3: random frame with idle gaps, then the same frame gap-free
        x = rand_word();
        send_frame(x, ref_crc(x), 1'b1);
        check_commit("t3_gaps", x);
        send_frame(x, ref_crc(x), 1'b0);
        check_commit("t3_nogap", x);

        // 4a: 0x52 followed by the leading '1' of A5 already forms A5, so the
        // remaining seven A5 bits are the first data bits of the frame
        x = rand_word();
        x[W-1 -: 7] = 7'b0100101;
        send_byte(8'h52, 1'b0);
        send_byte(8'hA5, 1'b0);
        for (int i = W - 8; i >= 0; i--) send_bit(x[i], 1'b0);
        send_byte(ref_crc(x), 1'b0);
        check_commit("t4_overlap", x);

        // 4b: sync words embedded in the data stay data
        x = rand_word();
        x[W-1 -: 8] = 8'hA5;
        x[80 -: 8]  = 8'hA5;
        x[7:0]      = 8'hA5;
        send_frame(x, ref_crc(x), 1'b0);
        check_commit("t4_embedded", x);

        // 5: reset mid-LOAD after a good commit
        x = rand_word();
        send_frame(x, ref_crc(x), 1'b0);
        check_commit("t5_pre", x);
        y = rand_word();
        send_byte(8'hA5, 1'b0);
        for (int i = W - 1; i >= W - 60; i--) send_bit(y[i], 1'b0);
        reset = 1'b0;
        #1;
        chk("t5_rst_bitstream", bitstream, '0);
        chk("t5_rst_done", cfg_done, 1'b0);
        chk("t5_rst_error", cfg_error, 1'b0);
        chk("t5_rst_ready", cfg_ready, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_frame(y, ref_crc(y), 1'b0);
        check_commit("t5_post", y);

        // 6: back-to-back X then Y; done drops exactly at Y's sync match
        x = rand_word();
        y = rand_word();
        send_frame(x, ref_crc(x), 1'b0);
        check_commit("t6_x", x);
        for (int i = 7; i >= 1; i--) send_bit(1'((8'hA5 >> i) & 8'h01), 1'b0);
        chk("t6_done_before_sync", cfg_done, 1'b1);
        send_bit(1'b1, 1'b0);
        chk("t6_done_at_sync", cfg_done, 1'b0);
        chk("t6_keep_x", bitstream, x);
        send_data(y, 1'b0);
        send_byte(ref_crc(y), 1'b0);
        chk("t6_keep_x_check", bitstream, x);
        check_commit("t6_y", y);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
